red: RTL and testbench

RED -- requirements
Module: red

---
 rtl/red_pkg.sv | 47 ++++
 rtl/red_fold.sv | 64 ++++++
 rtl/red.sv | 64 ++++++
 tb/tb_red.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/red_pkg.sv
// ---------------------------------------------------------------------------
// red_pkg
//
// Purpose:
//   Shared constants for the GF(2^163) reduction block. The field is defined
//   by the pentanomial f(x) = x^163 + x^7 + x^6 + x^3 + 1. This package holds
//   the field degree, the widths of an unreduced product and of a reduced
//   element, and the tap positions of the low part of f(x).
//
// Contents:
//   FIELD_M       field degree (163)
//   WIDE_W        width of an unreduced polynomial (2*FIELD_M = 326)
//   NARROW_W      width of a reduced field element (FIELD_M = 163)
//   TAP_A..TAP_D  exponents of the low terms of f(x): 7, 6, 3, 0
//   POLY_LOW      f(x) with the leading x^163 term dropped (163'h...C9)
//   wideT/fieldT  convenience vector types for the two widths
// ---------------------------------------------------------------------------
package red_pkg;

  localparam int FIELD_M  = 163;
  localparam int WIDE_W   = 2 * FIELD_M;
  localparam int NARROW_W = FIELD_M;

  // Exponents of the non-leading terms of the reduction pentanomial.
  localparam int TAP_A = 7;
  localparam int TAP_B = 6;
  localparam int TAP_C = 3;
  localparam int TAP_D = 0;

  typedef logic [WIDE_W-1:0]   wideT;
  typedef logic [NARROW_W-1:0] fieldT;

  // Builds the low part of f(x) from the tap list so the two can never
  // disagree. x^163 itself is implicit: it is the term being folded away.
  function automatic fieldT tapsToPoly();
    fieldT p;
    p        = '0;
    p[TAP_A] = 1'b1;
    p[TAP_B] = 1'b1;
    p[TAP_C] = 1'b1;
    p[TAP_D] = 1'b1;
    return p;
  endfunction

  localparam fieldT POLY_LOW = tapsToPoly();

endpackage

// File: rtl/red_fold.sv
// ---------------------------------------------------------------------------
// red_fold
//
// Purpose:
//   Purely combinational reduction of a 2M-bit polynomial over GF(2) modulo
//   f(x) = x^M + POLY(x). Every term x^k with k >= M is rewritten as
//   x^(k-M) * POLY(x) and XORed back into the low part. For the 163-bit
//   pentanomial two folds are enough:
//     fold 1: bits [2M-1:M] (degree up to 2M-1) land at degree <= M-1+7,
//             leaving at most 7 bits above x^(M-1);
//     fold 2: those 7 bits land at degree <= 6+7 = 13, well below M.
//   The result is therefore fully reduced to degree <= M-1.
//
// Ports:
//   i_d  input  [2M-1:0]  unreduced polynomial, bit i = coeff of x^i
//   o_r  output [M-1:0]   i_d mod f(x), bit i = coeff of x^i
// ---------------------------------------------------------------------------
module red_fold
  import red_pkg::*;
#(
  parameter int            M    = FIELD_M,
  parameter logic [M-1:0]  POLY = POLY_LOW
) (
  input  logic [2*M-1:0] i_d,
  output logic [M-1:0]   o_r
);

  logic [2*M-1:0] w_hi1;
  logic [2*M-1:0] w_fold1;
  logic [M-1:0]   w_hi2;
  logic [M-1:0]   w_fold2;

  // First fold: the whole upper half of the input is multiplied by POLY and
  // added to the lower half. The upper half is zero-extended to 2M bits so
  // the shifted copies keep the bits that spill past x^(M-1); those spilled
  // bits are what the second fold has to clean up. POLY is a parameter, so
  // the if only selects which shifted copies become XOR inputs.
  always_comb begin
    w_hi1   = {{M{1'b0}}, i_d[2*M-1:M]};
    w_fold1 = {{M{1'b0}}, i_d[M-1:0]};
    for (int j = 0; j < M; j++) begin
      if (POLY[j]) begin
        w_fold1 = w_fold1 ^ (w_hi1 << j);
      end
    end
  end

  // Second fold: whatever survived above x^(M-1) after the first fold is
  // folded once more. Only a handful of low bits of w_hi2 can be non-zero,
  // so the shifted copies stay inside M bits and the M-wide arithmetic here
  // never drops a real term.
  always_comb begin
    w_hi2   = w_fold1[2*M-1:M];
    w_fold2 = w_fold1[M-1:0];
    for (int j = 0; j < M; j++) begin
      if (POLY[j]) begin
        w_fold2 = w_fold2 ^ (w_hi2 << j);
      end
    end
  end

  assign o_r = w_fold2;

endmodule

// File: rtl/red.sv
// ---------------------------------------------------------------------------
// red
//
// Purpose:
//   Registered GF(2^163) reduction. The combinational red_fold network
//   reduces D each cycle; this wrapper only adds the result and valid
//   registers, giving one cycle of latency and a full result every cycle
//   with no stalls.
//
// Ports:
//   clk        input          rising-edge clock
//   rst        input          synchronous active-high reset
//   in_valid   input          D is valid this cycle
//   D          input  [2M-1:0] unreduced polynomial, bit i = coeff of x^i
//   out_valid  output          r holds a result captured at the last edge
//   r          output [M-1:0]  D mod f(x), bit i = coeff of x^i
// ---------------------------------------------------------------------------
module red
  import red_pkg::*;
#(
  parameter int            M    = FIELD_M,
  parameter logic [M-1:0]  POLY = POLY_LOW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [2*M-1:0] D,
  output logic           out_valid,
  output logic [M-1:0]   r
);

  logic [M-1:0] w_reduced;
  logic [M-1:0] r_result;
  logic         r_valid;

  // The reduction itself is a pure XOR network with no state.
  red_fold #(
    .M    (M),
    .POLY (POLY)
  ) u_fold (
    .i_d (D),
    .o_r (w_reduced)
  );

  // Output registers. Reset wins over a simultaneous input so a word
  // presented during reset is dropped. Outside reset the valid flag simply
  // follows in_valid, while the result register only loads on a valid
  // input and otherwise keeps the last result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_reduced;
      end
    end
  end

  assign r         = r_result;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_red.sv
// ---------------------------------------------------------------------------
// tb_red
//
// Purpose:
//   Self-checking bench for red. Stimulus is driven on the falling edge; at
//   the same time the expected (out_valid, r) pair for the following rising
//   edge is pushed into a scoreboard queue. A monitor pops one entry shortly
//   after every rising edge and compares it with the DUT outputs. Expected
//   results come from spec constants or from a bit-serial long-division
//   model of D mod f(x).
// ---------------------------------------------------------------------------
module tb_red;

  localparam int M  = 163;
  localparam int WW = 2 * M;

  typedef struct {
    logic         v;
    logic [M-1:0] r;
    string        tag;
  } expT;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [WW-1:0] D;
  logic          out_valid;
  logic [M-1:0]  r;

  expT sbQ[$];
  int  vecCount;
  int  missCount;

  logic [M-1:0] modelR;

  red dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .D         (D),
    .out_valid (out_valid),
    .r         (r)
  );

  // Free-running clock, first rising edge at 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference reduction: classic shift-and-subtract long division by the
  // full f(x) = x^163 + x^7 + x^6 + x^3 + 1, from the top bit downwards.
  function automatic logic [M-1:0] refMod(input logic [WW-1:0] d);
    logic [WW-1:0] rem;
    logic [WW-1:0] fPoly;
    rem   = d;
    fPoly = '0;
    fPoly[163] = 1'b1;
    fPoly[7]   = 1'b1;
    fPoly[6]   = 1'b1;
    fPoly[3]   = 1'b1;
    fPoly[0]   = 1'b1;
    for (int i = WW - 1; i >= M; i--) begin
      if (rem[i]) begin
        rem = rem ^ (fPoly << (i - M));
      end
    end
    return rem[M-1:0];
  endfunction

  // Single comparison point: counts every comparison and reports misses.
  task automatic checkOutput(input string tag, input logic [M-1:0] obs,
                             input logic [M-1:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs and queues what the DUT must show after the
  // next rising edge. useExp lets a vector carry a hand-computed result;
  // otherwise the long-division model supplies it.
  task automatic applyStimulus(input string tag, input logic rstIn,
                               input logic validIn, input logic [WW-1:0] dIn,
                               input logic useExp, input logic [M-1:0] expR);
    expT e;
    @(negedge clk);
    rst      = rstIn;
    in_valid = validIn;
    D        = dIn;
    if (rstIn) begin
      modelR = '0;
      e.v    = 1'b0;
    end else begin
      e.v = validIn;
      if (validIn) begin
        modelR = useExp ? expR : refMod(dIn);
      end
    end
    e.r   = modelR;
    e.tag = tag;
    sbQ.push_back(e);
  endtask

  // Monitor: one scoreboard entry is consumed per rising edge.
  always @(posedge clk) begin
    expT e;
    #1;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput({e.tag, ".valid"}, {{(M-1){1'b0}}, out_valid},
                  {{(M-1){1'b0}}, e.v});
      checkOutput({e.tag, ".r"}, r, e.r);
    end
  end

  // Watchdog so the run always ends with a summary line.
  initial begin
    #500000;
    missCount++;
    $display("[TB] FAIL watchdog: got timeout, expected normal end");
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    logic [WW-1:0] d;
    logic [WW-1:0] a;
    logic [WW-1:0] b;
    logic [63:0]   pat;
    logic [M-1:0]  e;
    logic [M-1:0]  zeroR;

    vecCount  = 0;
    missCount = 0;
    modelR    = '0;
    zeroR     = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    D         = '0;

    $display("[TB] starting red checks");

    applyStimulus("reset0", 1'b1, 1'b0, '0, 1'b0, zeroR);
    applyStimulus("reset1", 1'b1, 1'b0, '0, 1'b0, zeroR);

    applyStimulus("zero", 1'b0, 1'b1, '0, 1'b1, zeroR);

    d = '0; d[163] = 1'b1;
    applyStimulus("x163", 1'b0, 1'b1, d, 1'b1, 163'hC9);
    d = '0; d[164] = 1'b1;
    applyStimulus("x164", 1'b0, 1'b1, d, 1'b1, 163'h192);
    d = '0; d[163] = 1'b1; d[0] = 1'b1;
    applyStimulus("x163p1", 1'b0, 1'b1, d, 1'b1, 163'hC8);
    d = '0; d[325] = 1'b1;
    e = 163'h2844; e[162] = 1'b1;
    applyStimulus("x325", 1'b0, 1'b1, d, 1'b1, e);
    d = '0; d[63:0] = 64'h1234567890ABCDEF;
    applyStimulus("small", 1'b0, 1'b1, d, 1'b1, 163'h1234567890ABCDEF);
    d = '0; d[162:0] = '1;
    applyStimulus("top162", 1'b0, 1'b1, d, 1'b1, '1);

    applyStimulus("idle0", 1'b0, 1'b0, '1, 1'b0, zeroR);
    applyStimulus("idle1", 1'b0, 1'b0, '0, 1'b0, zeroR);

    d = '1;
    applyStimulus("ones", 1'b0, 1'b1, d, 1'b0, zeroR);
    pat = 64'hAAAAAAAAAAAAAAAA;
    for (int i = 0; i < WW; i++) d[i] = pat[i % 64];
    applyStimulus("alt", 1'b0, 1'b1, d, 1'b0, zeroR);
    pat = 64'h1234567890ABCDEF;
    for (int i = 0; i < WW; i++) d[i] = pat[i % 64];
    applyStimulus("rep", 1'b0, 1'b1, d, 1'b0, zeroR);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < WW; i++) d[i] = 1'($urandom_range(0, 1));
      applyStimulus($sformatf("rand%0d", k), 1'b0, 1'b1, d, 1'b0, zeroR);
    end

    for (int i = 0; i < WW; i++) a[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < WW; i++) b[i] = 1'($urandom_range(0, 1));
    applyStimulus("linA", 1'b0, 1'b1, a, 1'b0, zeroR);
    applyStimulus("linB", 1'b0, 1'b1, b, 1'b0, zeroR);
    applyStimulus("linAB", 1'b0, 1'b1, a ^ b, 1'b1, refMod(a) ^ refMod(b));

    d = '0; d[163] = 1'b1;
    applyStimulus("rstValid", 1'b1, 1'b1, d, 1'b0, zeroR);
    applyStimulus("rstRelease", 1'b0, 1'b0, d, 1'b0, zeroR);
    d = '0; d[164] = 1'b1;
    applyStimulus("afterRst", 1'b0, 1'b1, d, 1'b1, 163'h192);
    applyStimulus("tail", 1'b0, 1'b0, '0, 1'b0, zeroR);

    repeat (3) @(posedge clk);
    #2;
    checkOutput("drain", M'(sbQ.size()), zeroR);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
